// File: rtl/uart_frame_parser.sv
// Frame parser behind uart_rx: assembles AA,CMD,LEN,payload,CHK frames, checks XOR checksum, reports errors.
// Optional inter-byte timeout is compiled in with `define FRAME_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int MAX_LEN     = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 iCLK,
  input  logic                 RST_n,
  input  logic [7:0]           rxd,
  input  logic                 RECEIVE_END,
  output logic                 frame_valid,
  output logic [7:0]           frame_cmd,
  output logic [7:0]           frame_len,
  output logic [MAX_LEN*8-1:0] frame_payload,
  output logic                 frame_err,
  output logic [1:0]           err_code,
  output logic                 busy,
  output logic [7:0]           frame_cnt
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_DATA, S_CHK} state_t;

  state_t                   state_q, state_d;
  logic [7:0]               cmd_q, cmd_d, len_q, len_d, chk_q, chk_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [MAX_LEN-1:0][7:0]  buf_q, buf_d;
  logic                     vld_q, vld_d, err_q, err_d;
  logic [1:0]               code_q, code_d;
  logic [7:0]               ocmd_q, ocmd_d, olen_q, olen_d, cnt_q, cnt_d;
  logic [MAX_LEN-1:0][7:0]  opay_q, opay_d;
  logic                     tmo;

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmr_q, tmr_d;

  // A strobe in the expiry cycle wins over the timeout.
  always_comb begin
    tmo   = (state_q != S_IDLE) && !RECEIVE_END && (tmr_q == TW'(TIMEOUT_CYC - 1));
    tmr_d = (RECEIVE_END || state_q == S_IDLE || tmo) ? '0 : tmr_q + 1'b1;
  end

  always_ff @(posedge iCLK or negedge RST_n) begin
    if (!RST_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    chk_d   = chk_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    ocmd_d  = ocmd_q;
    olen_d  = olen_q;
    opay_d  = opay_q;
    cnt_d   = cnt_q;
    if (tmo) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = 2'd3;
    end else if (RECEIVE_END) begin
      unique case (state_q)
        S_IDLE: if (rxd == 8'hAA) state_d = S_CMD;
        S_CMD: begin
          cmd_d   = rxd;
          chk_d   = rxd;
          state_d = S_LEN;
        end
        S_LEN: begin
          chk_d = chk_q ^ rxd;
          len_d = rxd;
          if (rxd > 8'(MAX_LEN)) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_IDLE;
          end else if (rxd == 8'h00) begin
            state_d = S_CHK;
          end else begin
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          buf_d[idx_q] = rxd;
          chk_d        = chk_q ^ rxd;
          idx_d        = idx_q + 1'b1;
          if (8'(idx_q) == len_q - 8'd1) state_d = S_CHK;
        end
        S_CHK: begin
          state_d = S_IDLE;
          if (rxd == chk_q) begin
            vld_d  = 1'b1;
            code_d = 2'd0;
            ocmd_d = cmd_q;
            olen_d = len_q;
            cnt_d  = cnt_q + 8'd1;
            // Stale bytes from longer earlier frames must not leak out.
            for (int i = 0; i < MAX_LEN; i++)
              opay_d[i] = (i < 32'(len_q)) ? buf_q[i] : 8'h00;
          end else begin
            err_d  = 1'b1;
            code_d = 2'd2;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      len_q   <= '0;
      chk_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      ocmd_q  <= '0;
      olen_q  <= '0;
      opay_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      code_q  <= code_d;
      ocmd_q  <= ocmd_d;
      olen_q  <= olen_d;
      opay_q  <= opay_d;
      cnt_q   <= cnt_d;
    end
  end

  assign frame_valid   = vld_q;
  assign frame_err     = err_q;
  assign err_code      = code_q;
  assign frame_cmd     = ocmd_q;
  assign frame_len     = olen_q;
  assign frame_payload = opay_q;
  assign frame_cnt     = cnt_q;
  assign busy          = (state_q != S_IDLE);

endmodule
